cache_miss_ctrl: RTL and testbench

- Miss-handling controller for one set-associative cache. Sits directly downstream of the per-set way-select/replacement logic and consumes its hit, dirty and victim-tag outputs.
- On a miss it stalls the CPU, writes back a dirty victim line word-by-word, then refills the line from memory into the victim way.
- Releases the stall once the refilled line hits.

---
 rtl/cache_miss_ctrl.sv | 130 +++++++++++++
 tb/tb_cache_miss_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_ctrl.sv
// Miss-handling controller: dirty-victim writeback, line refill, stall release on hit.
// Optional macro CACHE_CRITICAL_WORD_FIRST_EN starts the refill at the requested word.
module cache_miss_ctrl #(
    parameter int SET_WIDTH  = 4,
    parameter int WORD_WIDTH = 2,
    parameter int TAG_WIDTH  = 24   // must equal 30 - SET_WIDTH - WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [31:0]           req_addr,
    input  logic                  hit,
    input  logic                  dirty,
    input  logic [TAG_WIDTH-1:0]  replace_tag,
    output logic                  cpu_stall,
    output logic                  way_en,
    output logic [WORD_WIDTH-1:0] wb_offset,
    input  logic [31:0]           wb_data,
    output logic                  fill_wen,
    output logic [WORD_WIDTH-1:0] fill_offset,
    output logic [31:0]           fill_data,
    output logic                  fill_done,
    output logic                  mem_req,
    output logic                  mem_wen,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, FINISH} state_t;

    state_t                state, state_nxt;
    logic [WORD_WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
    logic [31:0]           lat_addr, lat_addr_nxt;
    logic [TAG_WIDTH-1:0]  lat_vtag, lat_vtag_nxt;
    logic [WORD_WIDTH-1:0] refill_first;   // refill start word for the latched miss
    logic [WORD_WIDTH-1:0] miss_first;     // first cnt value loaded on a new miss
    logic                  unused_bits;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    assign refill_first = lat_addr[2 +: WORD_WIDTH];
    assign miss_first   = dirty ? '0 : req_addr[2 +: WORD_WIDTH];
`else
    assign refill_first = '0;
    assign miss_first   = '0;
`endif

    assign cnt_inc     = cnt + WORD_WIDTH'(1);
    assign unused_bits = &{1'b0, lat_addr[1:0], lat_addr[2 +: WORD_WIDTH]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_addr <= '0;
            lat_vtag <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            lat_addr <= lat_addr_nxt;
            lat_vtag <= lat_vtag_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        lat_addr_nxt = lat_addr;
        lat_vtag_nxt = lat_vtag;
        cpu_stall    = 1'b0;
        way_en       = 1'b0;
        wb_offset    = cnt;
        fill_wen     = 1'b0;
        fill_offset  = cnt;
        fill_data    = mem_rdata;
        fill_done    = 1'b0;
        mem_req      = 1'b0;
        mem_wen      = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        unique case (state)
            IDLE: begin
                cpu_stall = req_valid & ~hit;
                way_en    = req_valid & hit;
                if (req_valid && !hit) begin
                    lat_addr_nxt = req_addr;
                    lat_vtag_nxt = replace_tag;
                    cnt_nxt      = miss_first;
                    state_nxt    = dirty ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_wen   = 1'b1;
                mem_addr  = {lat_vtag, lat_addr[2+WORD_WIDTH +: SET_WIDTH], cnt, 2'b00};
                mem_wdata = wb_data;
                if (mem_ack) begin
                    cnt_nxt = cnt_inc;
                    if (cnt == '1) begin
                        cnt_nxt   = refill_first;
                        state_nxt = REFILL;
                    end
                end
            end
            REFILL: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = {lat_addr[31:2+WORD_WIDTH], cnt, 2'b00};
                if (mem_ack) begin
                    fill_wen = 1'b1;
                    cnt_nxt  = cnt_inc;
                    // Wrapping back to the start word means every word has been filled.
                    if (cnt_inc == refill_first) begin
                        fill_done = 1'b1;
                        state_nxt = FINISH;
                    end
                end
            end
            FINISH: begin
                cpu_stall = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Self-checking bench for cache_miss_ctrl: per-miss expected memory transaction queues.
module tb_cache_miss_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        hit;
    logic        dirty;
    logic [23:0] replace_tag;
    logic        cpu_stall;
    logic        way_en;
    logic [1:0]  wb_offset;
    logic [31:0] wb_data;
    logic        fill_wen;
    logic [1:0]  fill_offset;
    logic [31:0] fill_data;
    logic        fill_done;
    logic        mem_req;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rkey;
    logic [31:0] wb_base;

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ rkey;
    endfunction

    assign mem_rdata = rd_of(mem_addr);
    assign wb_data   = wb_base + ({30'b0, wb_offset} * 32'h11);

    cache_miss_ctrl #(.SET_WIDTH(4), .WORD_WIDTH(2), .TAG_WIDTH(24)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .hit(hit), .dirty(dirty), .replace_tag(replace_tag),
        .cpu_stall(cpu_stall), .way_en(way_en), .wb_offset(wb_offset), .wb_data(wb_data),
        .fill_wen(fill_wen), .fill_offset(fill_offset), .fill_data(fill_data),
        .fill_done(fill_done), .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // One complete miss; mode 0 = ack always, 1 = ack every 3rd cycle, 2 = random ack.
    task automatic run_miss(input logic [31:0] a, input logic d, input logic [23:0] vt,
                            input int mode, input int exp_stall);
        logic        q_wen[$];
        logic [31:0] q_addr[$];
        logic [31:0] q_data[$];
        logic [1:0]  q_off[$];
        logic [1:0]  first;
        logic [1:0]  w;
        logic [31:0] ea;
        logic        last;
        int          stalls;
        int          cyc;
        int          phase;

        first = 2'd0;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        first = a[3:2];
`endif
        if (d) begin
            for (int k = 0; k < 4; k++) begin
                w = 2'(k);
                q_wen.push_back(1'b1);
                q_addr.push_back({vt, a[7:4], w, 2'b00});
                q_data.push_back(wb_base + 32'(k) * 32'h11);
                q_off.push_back(w);
            end
        end
        for (int k = 0; k < 4; k++) begin
            w  = first + 2'(k);
            ea = {a[31:4], w, 2'b00};
            q_wen.push_back(1'b0);
            q_addr.push_back(ea);
            q_data.push_back(rd_of(ea));
            q_off.push_back(w);
        end

        @(posedge clk); #1;
        req_valid = 1'b1; hit = 1'b0; req_addr = a; dirty = d; replace_tag = vt;
        mem_ack = 1'b1;
        #1;
        checks++;
        if (cpu_stall !== 1'b1 || way_en !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL miss_cycle stall/way_en/mem_req got %b%b%b exp 100", cpu_stall, way_en, mem_req);
        end
        stalls = (cpu_stall === 1'b1) ? 1 : 0;
        phase  = 0;
        cyc    = 0;

        while (phase != 2 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            case (mode)
                0:       mem_ack = 1'b1;
                1:       mem_ack = (cyc % 3 == 0);
                default: mem_ack = 1'($urandom_range(0, 1));
            endcase
            dirty       = 1'($urandom_range(0, 1));
            replace_tag = 24'($urandom);
            if (phase == 1) hit = 1'b1;
            #1;
            if (cpu_stall === 1'b1) stalls++;

            if (phase == 0) begin
                checks++;
                if (mem_req !== 1'b1 || cpu_stall !== 1'b1 || way_en !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_ctl req/stall/way_en got %b%b%b exp 110", mem_req, cpu_stall, way_en);
                end
                checks++;
                if (mem_wen !== q_wen[0]) begin
                    errors++;
                    $display("FAIL mem_wen got %b exp %b", mem_wen, q_wen[0]);
                end
                checks++;
                if (mem_addr !== q_addr[0]) begin
                    errors++;
                    $display("FAIL mem_addr got %h exp %h", mem_addr, q_addr[0]);
                end
                if (q_wen[0]) begin
                    checks++;
                    if (mem_wdata !== q_data[0] || wb_offset !== q_off[0]) begin
                        errors++;
                        $display("FAIL wb_word wdata/offset got %h/%0d exp %h/%0d",
                                 mem_wdata, wb_offset, q_data[0], q_off[0]);
                    end
                end
                if (mem_ack) begin
                    last = (q_addr.size() == 1);
                    if (!q_wen[0]) begin
                        checks++;
                        if (fill_wen !== 1'b1 || fill_offset !== q_off[0] || fill_data !== q_data[0]) begin
                            errors++;
                            $display("FAIL fill_word wen/off/data got %b/%0d/%h exp 1/%0d/%h",
                                     fill_wen, fill_offset, fill_data, q_off[0], q_data[0]);
                        end
                    end
                    checks++;
                    if (fill_done !== last) begin
                        errors++;
                        $display("FAIL fill_done got %b exp %b", fill_done, last);
                    end
                    void'(q_wen.pop_front());
                    void'(q_addr.pop_front());
                    void'(q_data.pop_front());
                    void'(q_off.pop_front());
                    if (last) phase = 1;
                end else begin
                    checks++;
                    if (fill_wen !== 1'b0 || fill_done !== 1'b0) begin
                        errors++;
                        $display("FAIL no_ack_fill wen/done got %b%b exp 00", fill_wen, fill_done);
                    end
                end
            end else if (phase == 1) begin
                checks++;
                if (cpu_stall !== 1'b1 || mem_req !== 1'b0 || fill_wen !== 1'b0 ||
                    fill_done !== 1'b0 || way_en !== 1'b0) begin
                    errors++;
                    $display("FAIL finish stall/req/wen/done/way got %b%b%b%b%b exp 10000",
                             cpu_stall, mem_req, fill_wen, fill_done, way_en);
                end
                phase = 3;
            end else begin
                checks++;
                if (cpu_stall !== 1'b0 || way_en !== 1'b1 || mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL release stall/way_en/req got %b%b%b exp 010", cpu_stall, way_en, mem_req);
                end
                phase = 2;
            end
        end

        checks++;
        if (phase != 2) begin
            errors++;
            $display("FAIL miss_timeout phase got %0d exp 2", phase);
        end
        if (exp_stall >= 0) begin
            checks++;
            if (stalls != exp_stall) begin
                errors++;
                $display("FAIL stall_cycles got %0d exp %0d", stalls, exp_stall);
            end
        end
        req_valid = 1'b0;
        hit       = 1'b0;
        mem_ack   = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        req_valid = 1'b1; hit = 1'b0; mem_ack = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || fill_wen !== 1'b0 || fill_done !== 1'b0 ||
            cpu_stall !== 1'b1 || way_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_miss req/wen/done/stall/way got %b%b%b%b%b exp 00010",
                     mem_req, fill_wen, fill_done, cpu_stall, way_en);
        end
        hit = 1'b1;
        #1;
        checks++;
        if (cpu_stall !== 1'b0 || way_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_hit stall/way got %b%b exp 01", cpu_stall, way_en);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; hit = 1'b0; mem_ack = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_hit();
        @(posedge clk); #1;
        req_valid = 1'b1; hit = 1'b1; req_addr = 32'h100; mem_ack = 1'b1;
        #1;
        checks++;
        if (cpu_stall !== 1'b0 || way_en !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL hit stall/way/req got %b%b%b exp 010", cpu_stall, way_en, mem_req);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; hit = 1'b0; mem_ack = 1'b0;
        #1;
        checks++;
        if (cpu_stall !== 1'b0 || way_en !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle stall/way/req got %b%b%b exp 000", cpu_stall, way_en, mem_req);
        end
    endtask

    task automatic test_clean_miss();
        wb_base = 32'h0;
        run_miss(32'h1234, 1'b0, 24'h0, 0, 6);
    endtask

    task automatic test_dirty_miss();
        wb_base = 32'h0;
        run_miss(32'h0000_1034, 1'b1, 24'h0ABCDE, 0, 10);
    endtask

    task automatic test_delayed_ack();
        wb_base = 32'h5000_0000;
        run_miss(32'h8765_4328, 1'b1, 24'h123456, 1, -1);
    endtask

    task automatic test_critical_word();
        run_miss(32'h1238, 1'b0, 24'h0, 0, 6);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        req_valid = 1'b1; hit = 1'b0; req_addr = 32'h0000_2240; dirty = 1'b0; mem_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        checks++;
        if (fill_wen !== 1'b1 || fill_offset !== 2'd1) begin
            errors++;
            $display("FAIL second_ack wen/off got %b/%0d exp 1/1", fill_wen, fill_offset);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || fill_wen !== 1'b0 || fill_done !== 1'b0 || cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL async_reset req/wen/done/stall got %b%b%b%b exp 0001",
                     mem_req, fill_wen, fill_done, cpu_stall);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_req !== 1'b0 || fill_done !== 1'b0) begin
            errors++;
            $display("FAIL held_reset req/done got %b%b exp 00", mem_req, fill_done);
        end
        req_valid = 1'b0; mem_ack = 1'b0;
        reset = 1'b0;
        run_miss(32'h0000_2240, 1'b0, 24'h0, 0, 6);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            wb_base = $urandom;
            run_miss($urandom, 1'($urandom_range(0, 1)), 24'($urandom), 2, -1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog sim time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        rkey = $urandom; wb_base = '0;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; hit = 1'b0; dirty = 1'b0;
        replace_tag = '0; mem_ack = 1'b0;
        test_reset();
        test_hit();
        test_clean_miss();
        test_dirty_miss();
        test_delayed_ack();
        test_critical_word();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
